// File: rtl/doppler_phase_diff.sv
// Doppler front end: per-range-bin phase difference between consecutive chirps.
// Two-stage pipeline over a one-chirp phase memory; first chirp of a frame is reference.
module doppler_phase_diff #(
    parameter int NUM_BINS  = 64,
    parameter int BIN_W     = 6,
    parameter int OUT_SHIFT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             sample_valid,
    input  logic [15:0]      sample_phase,
    input  logic             sample_last,
    output logic             phase_valid,
    output logic [15:0]      phase_diff,
    output logic [BIN_W-1:0] diff_bin,
    output logic             chirp_err
);

    typedef enum logic {
        S_REF,
        S_RUN
    } state_e;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BIN_W-1:0]   wr_bin;
    logic [15:0]        mem_q [NUM_BINS];

    logic               s1_valid_q, s1_valid_d;
    logic               s1_emit_q, s1_emit_d;
    logic               s1_err_q, s1_err_d;
    logic [BIN_W-1:0]   s1_bin_q, s1_bin_d;
    logic [15:0]        s1_cur_q, s1_cur_d;
    logic [15:0]        s1_prev_q, s1_prev_d;

    logic               phase_valid_q, phase_valid_d;
    logic [15:0]        phase_diff_q, phase_diff_d;
    logic [BIN_W-1:0]   diff_bin_q, diff_bin_d;
    logic               chirp_err_q, chirp_err_d;

    logic signed [15:0] raw;
    logic signed [15:0] shifted;

    // Stage 1: bin tracking, state control, memory read of the previous chirp
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        wr_bin     = bin_q;
        s1_valid_d = 1'b0;
        s1_emit_d  = 1'b0;
        s1_err_d   = 1'b0;
        s1_bin_d   = s1_bin_q;
        s1_cur_d   = s1_cur_q;
        s1_prev_d  = s1_prev_q;
        if (frame_start) begin
            state_d = S_REF;
            bin_d   = '0;
            wr_bin  = '0;
            if (sample_valid) begin
                s1_valid_d = 1'b1;
                s1_bin_d   = '0;
                s1_cur_d   = sample_phase;
                s1_prev_d  = mem_q[0];
                bin_d      = sample_last ? '0 : BIN_W'(1);
            end
        end else if (sample_valid) begin
            s1_valid_d = 1'b1;
            s1_emit_d  = (state_q == S_RUN);
            s1_bin_d   = bin_q;
            s1_cur_d   = sample_phase;
            s1_prev_d  = mem_q[bin_q];
            if (sample_last) begin
                bin_d = '0;
                if (bin_q == LAST_BIN) begin
                    state_d = S_RUN;
                end else begin
                    state_d  = S_REF;
                    s1_err_d = 1'b1;
                end
            end else begin
                bin_d = bin_q + 1'b1;
            end
        end
    end

    // Stage 2: wrapped difference, arithmetic scaling, output hold
    always_comb begin
        raw           = s1_cur_q - s1_prev_q;
        shifted       = raw >>> OUT_SHIFT;
        phase_valid_d = s1_valid_q & s1_emit_q;
        chirp_err_d   = s1_valid_q & s1_err_q;
        phase_diff_d  = phase_diff_q;
        diff_bin_d    = diff_bin_q;
        if (phase_valid_d) begin
            phase_diff_d = shifted;
            diff_bin_d   = s1_bin_q;
        end
    end

    // Read-before-write: stage 1 captures the old word on the same edge
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            mem_q[wr_bin] <= sample_phase;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REF;
            bin_q         <= '0;
            s1_valid_q    <= 1'b0;
            s1_emit_q     <= 1'b0;
            s1_err_q      <= 1'b0;
            s1_bin_q      <= '0;
            s1_cur_q      <= '0;
            s1_prev_q     <= '0;
            phase_valid_q <= 1'b0;
            phase_diff_q  <= '0;
            diff_bin_q    <= '0;
            chirp_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bin_q         <= bin_d;
            s1_valid_q    <= s1_valid_d;
            s1_emit_q     <= s1_emit_d;
            s1_err_q      <= s1_err_d;
            s1_bin_q      <= s1_bin_d;
            s1_cur_q      <= s1_cur_d;
            s1_prev_q     <= s1_prev_d;
            phase_valid_q <= phase_valid_d;
            phase_diff_q  <= phase_diff_d;
            diff_bin_q    <= diff_bin_d;
            chirp_err_q   <= chirp_err_d;
        end
    end

    assign phase_valid = phase_valid_q;
    assign phase_diff  = phase_diff_q;
    assign diff_bin    = diff_bin_q;
    assign chirp_err   = chirp_err_q;

endmodule
